// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one block-wide main memory port between the instruction cache
//   controller (read-only refills) and the data cache controller (refills
//   and dirty-block writebacks). Each cache sees the same read/write/
//   busywait handshake it would see on a private memory. Transactions are
//   serialised, returned blocks are registered per side, and contended
//   requests alternate so neither side starves.
//
// Ports
//   clock, reset         : system clock (posedge), async active-high reset
//   i_mem_read           : instruction block read request
//   i_mem_address        : instruction block address
//   i_mem_readdata       : registered block returned to the instruction side
//   i_mem_busywait       : instruction-side stall
//   d_mem_read/_write    : data block read / writeback request
//   d_mem_address        : data block address
//   d_mem_writedata      : writeback block
//   d_mem_readdata       : registered block returned to the data side
//   d_mem_busywait       : data-side stall
//   mem_read/_write      : memory strobes, held for the whole access
//   mem_address          : memory block address
//   mem_writedata        : memory write block
//   mem_readdata         : memory read block
//   mem_busywait         : memory busy, high while an access is in progress
//
// state     | meaning
// ----------+-----------------------------------------------------
// S_IDLE    | no grant; requests evaluated every posedge
// S_GRANT_I | instruction side owns the memory port
// S_GRANT_D | data side owns the memory port
// S_DONE_I  | one-cycle completion, i_mem_busywait released
// S_DONE_D  | one-cycle completion, d_mem_busywait released
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128,
  parameter bit D_FIRST     = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_mem_read,
  input  logic [ADDR_WIDTH-1:0]  i_mem_address,
  output logic [BLOCK_WIDTH-1:0] i_mem_readdata,
  output logic                   i_mem_busywait,
  input  logic                   d_mem_read,
  input  logic                   d_mem_write,
  input  logic [ADDR_WIDTH-1:0]  d_mem_address,
  input  logic [BLOCK_WIDTH-1:0] d_mem_writedata,
  output logic [BLOCK_WIDTH-1:0] d_mem_readdata,
  output logic                   d_mem_busywait,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [BLOCK_WIDTH-1:0] mem_writedata,
  input  logic [BLOCK_WIDTH-1:0] mem_readdata,
  input  logic                   mem_busywait
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT_I, S_GRANT_D, S_DONE_I, S_DONE_D
  } state_t;

  typedef enum logic [1:0] {LG_NONE, LG_I, LG_D} last_t;

  state_t                 r_state;
  state_t                 w_next;
  last_t                  r_last;
  logic                   r_seen_busy;
  logic                   r_mem_read;
  logic                   r_mem_write;
  logic [ADDR_WIDTH-1:0]  r_address;
  logic [BLOCK_WIDTH-1:0] r_writedata;
  logic [BLOCK_WIDTH-1:0] r_i_readdata;
  logic [BLOCK_WIDTH-1:0] r_d_readdata;

  logic w_req_i;
  logic w_req_d;
  logic w_complete;

  assign w_req_i = i_mem_read;
  assign w_req_d = d_mem_read | d_mem_write;

  // Memory may not raise busywait on the first granted cycle, so completion
  // requires having seen it high at least once.
  assign w_complete = r_seen_busy & ~mem_busywait;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_i && w_req_d) begin
          if (r_last == LG_I)      w_next = S_GRANT_D;
          else if (r_last == LG_D) w_next = S_GRANT_I;
          else                     w_next = D_FIRST ? S_GRANT_D : S_GRANT_I;
        end else if (w_req_d) begin
          w_next = S_GRANT_D;
        end else if (w_req_i) begin
          w_next = S_GRANT_I;
        end
      end
      S_GRANT_I: if (w_complete) w_next = S_DONE_I;
      S_GRANT_D: if (w_complete) w_next = S_DONE_D;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last       <= LG_NONE;
      r_seen_busy  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_i_readdata <= '0;
      r_d_readdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_next == S_GRANT_I) begin
            r_address   <= i_mem_address;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_seen_busy <= 1'b0;
          end else if (w_next == S_GRANT_D) begin
            // read+write together is a writeback
            r_address   <= d_mem_address;
            r_writedata <= d_mem_writedata;
            r_mem_write <= d_mem_write;
            r_mem_read  <= ~d_mem_write;
            r_seen_busy <= 1'b0;
          end
        end
        S_GRANT_I, S_GRANT_D: begin
          if (w_complete) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_seen_busy <= 1'b0;
            if (r_state == S_GRANT_I) begin
              r_last <= LG_I;
              if (r_mem_read) r_i_readdata <= mem_readdata;
            end else begin
              r_last <= LG_D;
              if (r_mem_read) r_d_readdata <= mem_readdata;
            end
          end else if (mem_busywait) begin
            r_seen_busy <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_address    = r_address;
  assign mem_writedata  = r_writedata;
  assign i_mem_readdata = r_i_readdata;
  assign d_mem_readdata = r_d_readdata;

  // Stalls are released only in the side's own DONE cycle; reset forces
  // them low so a requester never stalls on a held-in-reset arbiter.
  assign i_mem_busywait = ~reset & w_req_i & (r_state != S_DONE_I);
  assign d_mem_busywait = ~reset & w_req_d & (r_state != S_DONE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW  = 28;
  localparam int BW  = 128;
  localparam int LAT = 5;

  localparam logic [BW-1:0] DEADBEEF = 128'hDEAD0000_11112222_33334444_5555BEEF;
  localparam logic [BW-1:0] WD1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [BW-1:0] WD2 = 128'hAAAA_5555_AAAA_5555_0F0F_F0F0_1234_5678;
  localparam logic [BW-1:0] WD3 = 128'hC0DE_C0DE_0000_1111_2222_3333_4444_5555;
  localparam logic [BW-1:0] WD4 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_mem_read = 1'b0;
  logic [AW-1:0] i_mem_address = '0;
  logic [BW-1:0] i_mem_readdata;
  logic          i_mem_busywait;
  logic          d_mem_read = 1'b0;
  logic          d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_address = '0;
  logic [BW-1:0] d_mem_writedata = '0;
  logic [BW-1:0] d_mem_readdata;
  logic          d_mem_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_writedata;
  logic [BW-1:0] mem_readdata;
  logic          mem_busywait;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .D_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_readdata(i_mem_readdata), .i_mem_busywait(i_mem_busywait),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_writedata(d_mem_writedata),
    .d_mem_readdata(d_mem_readdata), .d_mem_busywait(d_mem_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pat(input logic [AW-1:0] a);
    return {4{4'hA, a}};
  endfunction

  // memory model: busy for LAT cycles starting the posedge after a strobe rises
  logic [BW-1:0] mem [256];
  logic m_busy, m_prev;
  int   m_cnt;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = pat(AW'(k));
    mem[8'h10] = DEADBEEF;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_prev <= 1'b0; m_cnt <= 0; mem_readdata <= '0;
    end else begin
      m_prev <= mem_read | mem_write;
      if (!m_busy && (mem_read | mem_write) && !m_prev) begin
        m_busy <= 1'b1; m_cnt <= LAT - 1;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          if (mem_write) mem[mem_address[7:0]] <= mem_writedata;
          else           mem_readdata <= mem[mem_address[7:0]];
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end
  assign mem_busywait = m_busy;

  // scoreboard
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
  } mem_op_t;

  mem_op_t       mem_q[$];
  logic [BW-1:0] i_q[$];
  logic [BW-1:0] d_q[$];

  task automatic exp_mem(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] wd);
    mem_op_t op;
    op.rd = rd; op.wr = wr; op.addr = a; op.wdata = wd;
    mem_q.push_back(op);
  endtask

  // monitor
  logic          mon_prev = 1'b0;
  logic          snap_rd, snap_wr;
  logic [AW-1:0] snap_addr;
  logic [BW-1:0] snap_wd;

  always @(negedge clock) begin
    mem_op_t op;
    if (!reset) begin
      if ((mem_read | mem_write) && !mon_prev) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_access", BW'(mem_address), '1);
        end else begin
          op = mem_q.pop_front();
          chk("mem_read", BW'(mem_read), BW'(op.rd));
          chk("mem_write", BW'(mem_write), BW'(op.wr));
          chk("mem_address", BW'(mem_address), BW'(op.addr));
          if (op.wr) chk("mem_writedata", mem_writedata, op.wdata);
        end
        snap_rd = mem_read; snap_wr = mem_write;
        snap_addr = mem_address; snap_wd = mem_writedata;
      end else if ((mem_read | mem_write) && mon_prev) begin
        chk("strobe_stable", BW'({mem_read, mem_write}), BW'({snap_rd, snap_wr}));
        chk("addr_stable", BW'(mem_address), BW'(snap_addr));
        if (snap_wr) chk("wdata_stable", mem_writedata, snap_wd);
      end
      if (m_busy) chk("strobe_held_while_busy", BW'(mem_read | mem_write), BW'(1));
      if (i_mem_read && !i_mem_busywait) begin
        if (i_q.size() == 0) chk("unexpected_i_done", i_mem_readdata, '1);
        else chk("i_mem_readdata", i_mem_readdata, i_q.pop_front());
      end
      if ((d_mem_read | d_mem_write) && !d_mem_busywait) begin
        if (d_q.size() == 0) chk("unexpected_d_done", d_mem_readdata, '1);
        else chk("d_mem_readdata", d_mem_readdata, d_q.pop_front());
      end
    end
    mon_prev = reset ? 1'b0 : (mem_read | mem_write);
  end

  // requester drivers: act 2ns after negedge, away from both edges
  task automatic wait_i();
    int k = 0;
    do begin @(negedge clock); #2; k++; end while (i_mem_busywait && k < 200);
    if (k >= 200) chk("i_timeout", BW'(i_mem_busywait), '0);
  endtask

  task automatic wait_d();
    int k = 0;
    do begin @(negedge clock); #2; k++; end while (d_mem_busywait && k < 200);
    if (k >= 200) chk("d_timeout", BW'(d_mem_busywait), '0);
  endtask

  task automatic do_i(input logic [AW-1:0] a);
    @(negedge clock); #2;
    i_mem_address = a; i_mem_read = 1'b1;
    wait_i();
    i_mem_read = 1'b0;
  endtask

  task automatic do_d(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] wd);
    @(negedge clock); #2;
    d_mem_address = a; d_mem_writedata = wd; d_mem_read = rd; d_mem_write = wr;
    wait_d();
    d_mem_read = 1'b0; d_mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with requests asserted during reset
    i_mem_read = 1'b1; d_mem_write = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_i_busywait", BW'(i_mem_busywait), '0);
    chk("rst_d_busywait", BW'(d_mem_busywait), '0);
    chk("rst_mem_strobes", BW'({mem_read, mem_write}), '0);
    chk("rst_mem_address", BW'(mem_address), '0);
    chk("rst_mem_writedata", mem_writedata, '0);
    chk("rst_i_readdata", i_mem_readdata, '0);
    chk("rst_d_readdata", d_mem_readdata, '0);
    #2; i_mem_read = 1'b0; d_mem_write = 1'b0; reset = 1'b0;

    // 1: instruction-only read, 5 busy cycles
    exp_mem(1'b1, 1'b0, 28'h10, '0);
    i_q.push_back(DEADBEEF);
    @(negedge clock); #2;
    i_mem_address = 28'h10; i_mem_read = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      chk("t1_d_busywait", BW'(d_mem_busywait), '0);
      chk("t1_i_busywait", BW'(i_mem_busywait), BW'(c != 8));
      chk("t1_mem_read", BW'(mem_read), BW'(c < 8));
      if (c < 8) chk("t1_mem_address", BW'(mem_address), BW'(28'h10));
    end
    #2; i_mem_read = 1'b0;
    @(negedge clock);
    chk("t1_i_readdata_hold", i_mem_readdata, DEADBEEF);

    // 2: simultaneous I read and D write from reset, D first
    @(negedge clock); #2; reset = 1'b1;
    @(negedge clock); #2; reset = 1'b0;
    exp_mem(1'b0, 1'b1, 28'h40, WD1);
    exp_mem(1'b1, 1'b0, 28'h20, '0);
    d_q.push_back('0);
    i_q.push_back(pat(28'h20));
    fork
      do_i(28'h20);
      do_d(1'b0, 1'b1, 28'h40, WD1);
    join

    // 3: continuous contention, strict alternation D,I,D,I,D,I
    exp_mem(1'b1, 1'b0, 28'h40, '0);
    exp_mem(1'b1, 1'b0, 28'h24, '0);
    exp_mem(1'b0, 1'b1, 28'h44, WD2);
    exp_mem(1'b1, 1'b0, 28'h28, '0);
    exp_mem(1'b1, 1'b0, 28'h48, '0);
    exp_mem(1'b1, 1'b0, 28'h2C, '0);
    d_q.push_back(WD1);
    d_q.push_back(WD1);
    d_q.push_back(pat(28'h48));
    i_q.push_back(pat(28'h24));
    i_q.push_back(pat(28'h28));
    i_q.push_back(pat(28'h2C));
    fork
      begin
        do_d(1'b1, 1'b0, 28'h40, '0);
        do_d(1'b0, 1'b1, 28'h44, WD2);
        do_d(1'b1, 1'b0, 28'h48, '0);
      end
      begin
        do_i(28'h24);
        do_i(28'h28);
        do_i(28'h2C);
      end
    join

    // 4: read and write together act as a write
    exp_mem(1'b0, 1'b1, 28'h50, WD3);
    d_q.push_back(pat(28'h48));
    do_d(1'b1, 1'b1, 28'h50, WD3);

    // 5: I withdraws mid-grant while D starts requesting
    exp_mem(1'b1, 1'b0, 28'h30, '0);
    exp_mem(1'b1, 1'b0, 28'h54, '0);
    d_q.push_back(pat(28'h54));
    @(negedge clock); #2;
    i_mem_address = 28'h30; i_mem_read = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    i_mem_read = 1'b0; i_mem_address = 28'h99;
    d_mem_address = 28'h54; d_mem_read = 1'b1;
    wait_d();
    d_mem_read = 1'b0;
    chk("t5_i_readdata", i_mem_readdata, pat(28'h30));

    // 6: reset during a data writeback, pending I request
    exp_mem(1'b0, 1'b1, 28'h58, WD4);
    exp_mem(1'b1, 1'b0, 28'h34, '0);
    i_q.push_back(pat(28'h34));
    @(negedge clock); #2;
    d_mem_address = 28'h58; d_mem_writedata = WD4; d_mem_write = 1'b1;
    repeat (3) @(negedge clock);
    #2; i_mem_address = 28'h34; i_mem_read = 1'b1;
    @(negedge clock);
    chk("t6_mem_write_before", BW'(mem_write), BW'(1));
    #2; reset = 1'b1;
    #1;
    chk("t6_rst_mem_write", BW'(mem_write), '0);
    chk("t6_rst_d_busywait", BW'(d_mem_busywait), '0);
    chk("t6_rst_i_busywait", BW'(i_mem_busywait), '0);
    chk("t6_rst_mem_address", BW'(mem_address), '0);
    chk("t6_rst_i_readdata", i_mem_readdata, '0);
    d_mem_write = 1'b0;
    @(negedge clock); #2; reset = 1'b0;
    @(negedge clock);
    chk("t6_regrant_mem_read", BW'(mem_read), BW'(1));
    chk("t6_regrant_addr", BW'(mem_address), BW'(28'h34));
    wait_i();
    i_mem_read = 1'b0;

    repeat (3) @(negedge clock);
    chk("mem_q_drained", BW'(mem_q.size()), '0);
    chk("i_q_drained", BW'(i_q.size()), '0);
    chk("d_q_drained", BW'(d_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit-block main memory port between two requesters: the instruction cache controller (read-only block refills) and the data cache controller (block refills and dirty-block writebacks).
- Sits between both cache controllers and the memory model, and presents each cache with the same read/write/busywait handshake it would see on a private memory.
- Serialises transactions, registers returned blocks and guarantees no starvation.

Parameters:
- ADDR_WIDTH, 28, block address width (byte address bits [31:4]).
- BLOCK_WIDTH, 128, bits per cache block.
- D_FIRST, 1, on a simultaneous request with no prior history, 1 grants the data cache first and 0 grants the instruction cache first.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- i_mem_read  input  1  instruction cache block read request.
- i_mem_address  input  ADDR_WIDTH  instruction block address.
- i_mem_readdata  output  BLOCK_WIDTH  registered block returned to the instruction cache.
- i_mem_busywait  output  1  instruction-side stall.
- d_mem_read  input  1  data cache block read request.
- d_mem_write  input  1  data cache block writeback request.
- d_mem_address  input  ADDR_WIDTH  data block address.
- d_mem_writedata  input  BLOCK_WIDTH  writeback block.
- d_mem_readdata  output  BLOCK_WIDTH  registered block returned to the data cache.
- d_mem_busywait  output  1  data-side stall.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_address  output  ADDR_WIDTH  memory block address.
- mem_writedata  output  BLOCK_WIDTH  memory write block.
- mem_readdata  input  BLOCK_WIDTH  memory read block.
- mem_busywait  input  1  memory busy; high while an access is in progress.

Behaviour:
- Reset (asynchronous): state IDLE; last_grant = none. All outputs are 0, including both readdata registers, both busywaits, mem_read, mem_write, mem_address and mem_writedata. Any in-flight memory access is abandoned with strobes dropped immediately.
- States:
  - IDLE: no grant. Evaluate requests at each posedge.
  - GRANT_I: instruction cache granted.
  - GRANT_D: data cache granted.
  - DONE_I: one-cycle completion for the instruction cache.
  - DONE_D: one-cycle completion for the data cache.
- IDLE transitions:
  - Only one side requesting: go to that side's GRANT state.
  - Both requesting: grant the side not equal to last_grant. If last_grant = none, D_FIRST decides.
  - d_mem_read and d_mem_write both high: treated as a write.
- On entry to a GRANT state:
  - Capture address, writedata and op (read/write) into registers.
  - Drive mem_read/mem_write and mem_address/mem_writedata from those registers, holding them stable for the whole access. Later changes on the requester inputs are ignored.
- Completion detection: a seen_busy flag is set at the first posedge in GRANT with mem_busywait = 1. Completion is the first posedge with seen_busy = 1 and mem_busywait = 0.
- At completion:
  - Read: latch mem_readdata into the granted side's readdata register.
  - Drop mem_read/mem_write to 0.
  - Set last_grant to the granted side and move to DONE_x.
- DONE_x: that side's busywait = 0 for exactly one cycle, then go to IDLE. The requester is expected to drop its request in this cycle. A request still asserted in IDLE is a new transaction.
- Busywait rule: x_mem_busywait = (x request asserted) AND NOT (state == DONE_x). The non-granted side stays stalled throughout.
- Latency: request high at posedge N with memory free gives mem_read high after posedge N. Requester busywait drops the cycle after the memory completion posedge. Best-case arbitration overhead is 2 cycles.
- Withdrawal mid-grant: the access still runs to memory completion because memory cannot abort. Returned data is latched but ignored, and the FSM passes through DONE as normal.
- Fairness: with continuous requests from both sides, grants strictly alternate, so neither side waits more than one foreign transaction.
- readdata registers change only at completion of their own side; they hold otherwise.
- Reset mid-GRANT: outputs drop asynchronously to 0. After release, re-arbitration starts from IDLE.

Test Plan:
- I-only read of 0x0000010 with memory returning 0xDEAD…BEEF after 5 busy cycles -> mem_read high 1 cycle after request, held with mem_address = 0x0000010 for the busy period. i_mem_readdata = 0xDEAD…BEEF, i_mem_busywait low exactly 1 cycle, d_mem_busywait stays 0.
- Simultaneous I read 0x20 and D write 0x40 from reset (D_FIRST = 1) -> D served first with mem_write and mem_writedata matching, then I read of 0x20. Each busywait is low only in its own DONE cycle.
- Both sides re-request continuously for 6 transactions -> grant order strictly D, I, D, I, D, I.
- D asserts read and write together -> memory sees mem_write = 1, mem_read = 0.
- I drops i_mem_read mid-grant and d_mem_read rises -> I access completes, i_mem_readdata updates, then D is granted. No strobe glitch occurs.
- reset pulsed during GRANT_D -> mem_write and both busywaits 0 immediately. A pending I request after release is granted within 1 cycle.
